uart_regs_fifo: RTL and testbench
=================================

# uart_regs_fifo

Parametrised successor to the UART CSR block: the same local-bus register file, now with a TX FIFO and an RX FIFO of configurable depth, sticky overflow flags and an interrupt output. It sits between the CPU local bus and the UART core. It buffers bytes in both directions, so software is no longer tied to one byte per status poll.

## Interface
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- STRB_W, DATA_W/8, write-strobe width
- TX_DEPTH, 8, TX FIFO entries; power of two, ≥2
- RX_DEPTH, 8, RX FIFO entries; power of two, ≥2
- BR_RST, 4'hf, reset value of CTRL.BR
- clk  in  1  sole clock; everything on posedge
- rst  in  1  synchronous, active-high reset
- ctrl_en_out  out  1  CTRL.EN
- ctrl_br_out  out  4  CTRL.BR
- ctrl_clk_out  out  8  CTRL.CLK
- tx_data_out  out  8  TX FIFO head byte
- tx_valid_out  out  1  TX FIFO non-empty AND EN
- tx_ready_in  in  1  core accepts the head byte (pop when tx_valid_out && tx_ready_in)
- rx_data_in  in  8  received byte
- rx_valid_in  in  1  one-cycle strobe, push rx_data_in
- irq_out  out  1  registered interrupt
- waddr, wdata, wen, wstrb  in  ADDR_W/DATA_W/1/STRB_W  write channel
- wready  out  1  constant 1
- raddr, ren  in  ADDR_W/1  read channel
- rdata  out  DATA_W  read data
- rvalid  out  1  read data valid

## Operation
- **0x00 CTRL**
  - EN[0], rw, reset 0.
  - TXFLUSH[1], RXFLUSH[2]: write-1 pulse, self-clearing, read 0; empties the FIFO on the next edge.
  - BR[7:4], rw, reset BR_RST.
  - CLK[15:8], rw, reset 0.
  - Byte lanes are gated by wstrb[0] and wstrb[1] respectively.
- **0x04 STAT**
  - Read-only bits: TXFULL[0], TXEMPTY[1], RXNE[2], RXFULL[3].
  - RXOVR[4], TXOVR[5]: sticky, write-1-to-clear.
  - TXCNT[15:8], RXCNT[23:16]: occupancy, zero-extended; range 0..DEPTH.
  - Set and clear of a sticky flag in the same cycle: set wins.
- **0x08 TXDATA**
  - A write with wstrb[0] pushes wdata[7:0].
  - Write while full: byte dropped, TXOVR set.
  - Reads return 0.
- **0x0C RXDATA**
  - A read pops the head byte: rdata[7:0] = byte, rdata[31] = 1.
  - Read while empty: returns 0, no pop, no flag.
- **0x10 IRQ_EN**: TXEIE[0], RXNEIE[1], OVRIE[2], rw, reset 0.
- irq_out <= (TXEIE & TXEMPTY) | (RXNEIE & RXNE) | (OVRIE & (RXOVR | TXOVR)).
- **RX path**
  - rx_valid_in is ignored while EN=0.
  - Push when full: byte dropped, RXOVR set.
  - Push and bus pop in the same cycle while full: both happen, no overflow.
- **FIFO rules**
  - Simultaneous push and pop: count unchanged. When empty, the push proceeds and the pop is ignored.
  - Flush in the same cycle as a push or pop: flush wins, count becomes 0.
  - Pointers wrap modulo DEPTH; full/empty are derived from a count of width clog2(DEPTH)+1.
- **Bus decode**
  - Unmapped writes are ignored.
  - Unmapped reads return 0 with rvalid.

## Timing
- Reset values:
  - ctrl_en_out 0, ctrl_br_out BR_RST, ctrl_clk_out 0.
  - tx_valid_out 0, tx_data_out 0.
  - irq_out 0, rdata 0, rvalid 0.
  - Both FIFOs empty, all flags 0.
- Writes take effect at the edge where wen=1. wready is always 1; no stall.
- Read latency is 1 cycle:
  - rdata and rvalid are registered from the ren cycle.
  - rvalid is high for exactly one cycle per ren cycle.
  - rdata is 0 whenever rvalid=0.
- Back-to-back ren cycles each return data; consecutive RXDATA reads pop consecutive bytes.
- The RX pop is committed at the ren edge, so STAT read in the following cycle already reflects it.
- tx_valid_out and tx_data_out are combinational from the FIFO registers and EN. A byte pushed at edge N is visible at tx_data_out after edge N.
- irq_out lags its sources by 1 cycle.
- rst during any activity: all state returns to reset values at that edge; FIFO contents are discarded.

## Structure
- Package uart_regs_pkg holds:
  - Register offsets (CTRL/STAT/TXDATA/RXDATA/IRQ_EN).
  - Bit-field positions.
  - CTRL reset constants.
- Sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, flush, din, dout, count, full, empty), instantiated once for TX and once for RX.
- The top level contains only decode, CTRL/IRQ_EN/flag registers and the read mux.

## Test plan
- Reset, then read every register → CTRL=0x000000F0, STAT=0x00000002, others 0; irq_out=0, rvalid pulses once per read.
- Write 0x41..0x48 to TXDATA with EN=1, tx_ready_in=0 → STAT.TXFULL=1, TXCNT=8. A 9th write sets TXOVR. Then raise tx_ready_in → tx_data_out sequence is 0x41..0x48, TXEMPTY=1.
- 9 rx_valid_in strobes (0x10..0x18) with EN=1 → RXFULL=1, RXOVR=1. Eight RXDATA reads return 0x80000010..0x80000017, then a ninth returns 0.
- RX full, rx_valid_in coinciding with an RXDATA read → no RXOVR, RXCNT stays 8.
- IRQ_EN=0x2, single RX byte → irq_out rises 2 cycles after rx_valid_in. RXDATA read → irq_out falls. Write STAT 0x10 → RXOVR cleared.
- TX half full, write CTRL TXFLUSH together with a TXDATA push the next cycle → TXCNT=0 after the flush edge and 1 after the push; rst mid-transfer → all reset values.

Source files
------------

// File: rtl/uart_regs_pkg.sv
// Register map, field positions and reset constants shared by the UART
// register file and its FIFOs.
package uart_regs_pkg;

    localparam logic [7:0] CTRL_OFF   = 8'h00;
    localparam logic [7:0] STAT_OFF   = 8'h04;
    localparam logic [7:0] TXDATA_OFF = 8'h08;
    localparam logic [7:0] RXDATA_OFF = 8'h0C;
    localparam logic [7:0] IRQEN_OFF  = 8'h10;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_TXFLUSH_BIT = 1;
    localparam int CTRL_RXFLUSH_BIT = 2;
    localparam int CTRL_BR_LSB      = 4;
    localparam int CTRL_CLK_LSB     = 8;

    localparam int STAT_TXFULL_BIT  = 0;
    localparam int STAT_TXEMPTY_BIT = 1;
    localparam int STAT_RXNE_BIT    = 2;
    localparam int STAT_RXFULL_BIT  = 3;
    localparam int STAT_RXOVR_BIT   = 4;
    localparam int STAT_TXOVR_BIT   = 5;
    localparam int STAT_TXCNT_LSB   = 8;
    localparam int STAT_RXCNT_LSB   = 16;

    localparam int IRQ_TXEIE_BIT  = 0;
    localparam int IRQ_RXNEIE_BIT = 1;
    localparam int IRQ_OVRIE_BIT  = 2;

    localparam int RXDATA_VALID_BIT = 31;

    localparam logic       CTRL_EN_RST  = 1'b0;
    localparam logic [7:0] CTRL_CLK_RST = 8'h00;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STAT,
        REG_TXDATA,
        REG_RXDATA,
        REG_IRQEN,
        REG_NONE
    } reg_sel_e;

endpackage

// File: rtl/uart_regs_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; flush beats push/pop, pop of an
// empty FIFO is ignored, push into a full FIFO only lands if a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: every signal gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define validity, and dout is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_regs_fifo.sv
// UART local-bus register file with TX/RX FIFOs, sticky overflow flags and a
// registered interrupt.
module uart_regs_fifo
    import uart_regs_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter int         DATA_W   = 32,
    parameter int         STRB_W   = DATA_W / 8,
    parameter int         TX_DEPTH = 8,
    parameter int         RX_DEPTH = 8,
    parameter logic [3:0] BR_RST   = 4'hf
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ctrl_en_out,
    output logic [3:0]        ctrl_br_out,
    output logic [7:0]        ctrl_clk_out,
    output logic [7:0]        tx_data_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in,
    input  logic [7:0]        rx_data_in,
    input  logic              rx_valid_in,
    output logic              irq_out,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wen,
    input  logic [STRB_W-1:0] wstrb,
    output logic              wready,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    function automatic reg_sel_e decode(input logic [ADDR_W-1:0] a);
        case (a)
            ADDR_W'(CTRL_OFF):   return REG_CTRL;
            ADDR_W'(STAT_OFF):   return REG_STAT;
            ADDR_W'(TXDATA_OFF): return REG_TXDATA;
            ADDR_W'(RXDATA_OFF): return REG_RXDATA;
            ADDR_W'(IRQEN_OFF):  return REG_IRQEN;
            default:             return REG_NONE;
        endcase
    endfunction

    logic              en_q, en_d;
    logic [3:0]        br_q, br_d;
    logic [7:0]        clk_div_q, clk_div_d;
    logic [2:0]        irq_en_q, irq_en_d;
    logic              rxovr_q, rxovr_d;
    logic              txovr_q, txovr_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    reg_sel_e wsel, rsel;
    logic     wr_ctrl_lo, wr_ctrl_hi, wr_stat, wr_irqen;
    logic     tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic     rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [7:0] rx_dout;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;

    assign wsel       = decode(waddr);
    assign rsel       = decode(raddr);
    assign wr_ctrl_lo = wen && (wsel == REG_CTRL) && wstrb[0];
    assign wr_ctrl_hi = wen && (wsel == REG_CTRL) && wstrb[1];
    assign wr_stat    = wen && (wsel == REG_STAT) && wstrb[0];
    assign wr_irqen   = wen && (wsel == REG_IRQEN) && wstrb[0];

    assign tx_push  = wen && (wsel == REG_TXDATA) && wstrb[0];
    assign tx_flush = wr_ctrl_lo && wdata[CTRL_TXFLUSH_BIT];
    assign tx_pop   = tx_valid_out && tx_ready_in;
    assign rx_push  = rx_valid_in && en_q;
    assign rx_flush = wr_ctrl_lo && wdata[CTRL_RXFLUSH_BIT];
    assign rx_pop   = ren && (rsel == REG_RXDATA) && !rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (wdata[7:0]),
        .dout  (tx_data_out),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (rx_data_in),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        en_d      = en_q;
        br_d      = br_q;
        clk_div_d = clk_div_q;
        irq_en_d  = irq_en_q;
        rxovr_d   = rxovr_q;
        txovr_d   = txovr_q;
        rdata_d   = '0;
        rvalid_d  = ren;

        if (wr_ctrl_lo) begin
            en_d = wdata[CTRL_EN_BIT];
            br_d = wdata[CTRL_BR_LSB +: 4];
        end
        if (wr_ctrl_hi) clk_div_d = wdata[CTRL_CLK_LSB +: 8];
        if (wr_irqen)   irq_en_d  = wdata[2:0];

        // Clear first so a same-cycle overflow set takes priority.
        if (wr_stat && wdata[STAT_RXOVR_BIT]) rxovr_d = 1'b0;
        if (wr_stat && wdata[STAT_TXOVR_BIT]) txovr_d = 1'b0;
        if (rx_push && rx_full && !rx_pop && !rx_flush) rxovr_d = 1'b1;
        if (tx_push && tx_full && !tx_pop && !tx_flush) txovr_d = 1'b1;

        if (ren) begin
            case (rsel)
                REG_CTRL: begin
                    rdata_d[CTRL_EN_BIT]         = en_q;
                    rdata_d[CTRL_BR_LSB +: 4]    = br_q;
                    rdata_d[CTRL_CLK_LSB +: 8]   = clk_div_q;
                end
                REG_STAT: begin
                    rdata_d[STAT_TXFULL_BIT]     = tx_full;
                    rdata_d[STAT_TXEMPTY_BIT]    = tx_empty;
                    rdata_d[STAT_RXNE_BIT]       = !rx_empty;
                    rdata_d[STAT_RXFULL_BIT]     = rx_full;
                    rdata_d[STAT_RXOVR_BIT]      = rxovr_q;
                    rdata_d[STAT_TXOVR_BIT]      = txovr_q;
                    rdata_d[STAT_TXCNT_LSB +: 8] = 8'(tx_count);
                    rdata_d[STAT_RXCNT_LSB +: 8] = 8'(rx_count);
                end
                REG_RXDATA: begin
                    if (!rx_empty) begin
                        rdata_d[7:0]             = rx_dout;
                        rdata_d[RXDATA_VALID_BIT] = 1'b1;
                    end
                end
                REG_IRQEN: rdata_d[2:0] = irq_en_q;
                default:   rdata_d = '0;
            endcase
        end

        irq_d = (irq_en_q[IRQ_TXEIE_BIT]  && tx_empty)
              | (irq_en_q[IRQ_RXNEIE_BIT] && !rx_empty)
              | (irq_en_q[IRQ_OVRIE_BIT]  && (rxovr_q || txovr_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= CTRL_EN_RST;
            br_q      <= BR_RST;
            clk_div_q <= CTRL_CLK_RST;
            irq_en_q  <= '0;
            rxovr_q   <= 1'b0;
            txovr_q   <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            en_q      <= en_d;
            br_q      <= br_d;
            clk_div_q <= clk_div_d;
            irq_en_q  <= irq_en_d;
            rxovr_q   <= rxovr_d;
            txovr_q   <= txovr_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign ctrl_en_out  = en_q;
    assign ctrl_br_out  = br_q;
    assign ctrl_clk_out = clk_div_q;
    assign tx_valid_out = !tx_empty && en_q;
    assign irq_out      = irq_q;
    assign wready       = 1'b1;
    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;

endmodule

// File: tb/tb_uart_regs_fifo.sv
// Directed bench for uart_regs_fifo: reads are scored by a negedge monitor
// against a queue of expected rdata; sideband outputs are checked inline.
module tb_uart_regs_fifo;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STAT   = 32'h04;
    localparam logic [31:0] A_TXDATA = 32'h08;
    localparam logic [31:0] A_RXDATA = 32'h0C;
    localparam logic [31:0] A_IRQEN  = 32'h10;
    localparam logic [31:0] A_UNMAP  = 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_en_out;
    logic [3:0]  ctrl_br_out;
    logic [7:0]  ctrl_clk_out;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic        irq_out;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
    logic        wready;
    logic [31:0] raddr;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    uart_regs_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_en_out  (ctrl_en_out),
        .ctrl_br_out  (ctrl_br_out),
        .ctrl_clk_out (ctrl_clk_out),
        .tx_data_out  (tx_data_out),
        .tx_valid_out (tx_valid_out),
        .tx_ready_in  (tx_ready_in),
        .rx_data_in   (rx_data_in),
        .rx_valid_in  (rx_valid_in),
        .irq_out      (irq_out),
        .waddr        (waddr),
        .wdata        (wdata),
        .wen          (wen),
        .wstrb        (wstrb),
        .wready       (wready),
        .raddr        (raddr),
        .ren          (ren),
        .rdata        (rdata),
        .rvalid       (rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Read-data monitor: every rvalid pops one expectation.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rvalid: got rdata 0x%08h, expected no read response", rdata);
            end else begin
                check(name_q.pop_front(), rdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb = 4'hf);
        waddr = addr;
        wdata = data;
        wstrb = strb;
        wen   = 1'b1;
        tick();
        wen   = 1'b0;
    endtask

    task automatic expect_read(input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        raddr = addr;
        ren   = 1'b1;
        expect_read(exp, name);
        tick();
        ren   = 1'b0;
    endtask

    task automatic rx_strobe(input logic [7:0] b);
        rx_data_in  = b;
        rx_valid_in = 1'b1;
        tick();
        rx_valid_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},     {31'b0, ctrl_en_out},  32'h0);
        check({tag, "_br"},     {28'b0, ctrl_br_out},  32'hf);
        check({tag, "_clk"},    {24'b0, ctrl_clk_out}, 32'h0);
        check({tag, "_txv"},    {31'b0, tx_valid_out}, 32'h0);
        check({tag, "_txd"},    {24'b0, tx_data_out},  32'h0);
        check({tag, "_irq"},    {31'b0, irq_out},      32'h0);
        check({tag, "_rvalid"}, {31'b0, rvalid},       32'h0);
        check({tag, "_rdata"},  rdata,                 32'h0);
    endtask

    initial begin
        rst = 1'b1; tx_ready_in = 1'b0; rx_data_in = '0; rx_valid_in = 1'b0;
        waddr = '0; wdata = '0; wen = 1'b0; wstrb = '0; raddr = '0; ren = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and register readback
        check_reset_outputs("rst");
        check("wready", {31'b0, wready}, 32'h1);
        bus_read(A_CTRL,   32'h0000_00F0, "rst_ctrl");
        bus_read(A_STAT,   32'h0000_0002, "rst_stat");
        bus_read(A_TXDATA, 32'h0,         "rst_txdata");
        bus_read(A_RXDATA, 32'h0,         "rst_rxdata");
        bus_read(A_IRQEN,  32'h0,         "rst_irqen");
        bus_read(A_UNMAP,  32'h0,         "unmapped_read");
        rx_strobe(8'h33);
        bus_read(A_STAT,   32'h0000_0002, "rx_ignored_en0");

        // CTRL writes and byte lanes
        bus_write(A_CTRL, 32'h0000_12F1);
        check("ctrl_en", {31'b0, ctrl_en_out}, 32'h1);
        check("ctrl_clk", {24'b0, ctrl_clk_out}, 32'h12);
        bus_write(A_CTRL, 32'h0000_AB00, 4'b0010);
        bus_write(A_UNMAP, 32'hFFFF_FFFF);
        bus_read(A_CTRL, 32'h0000_ABF1, "ctrl_lane1_only");

        // TX fill, overflow, drain
        for (int i = 0; i < 8; i++) begin
            bus_write(A_TXDATA, 32'h41 + 32'(i));
            if (i == 0) begin
                check("tx_valid_first", {31'b0, tx_valid_out}, 32'h1);
                check("tx_data_first", {24'b0, tx_data_out}, 32'h41);
            end
        end
        bus_read(A_STAT, 32'h0000_0801, "tx_full");
        bus_write(A_TXDATA, 32'h49);
        bus_read(A_STAT, 32'h0000_0821, "tx_ovr");
        tx_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_seq_%0d", i), {23'b0, tx_valid_out, tx_data_out}, 32'h141 + 32'(i));
            tick();
        end
        tx_ready_in = 1'b0;
        check("tx_drained_valid", {31'b0, tx_valid_out}, 32'h0);
        bus_read(A_STAT, 32'h0000_0022, "tx_empty_ovr");
        bus_write(A_STAT, 32'h20);
        bus_read(A_STAT, 32'h0000_0002, "txovr_cleared");

        // RX fill with overflow, drain, read while empty
        for (int i = 0; i < 9; i++) rx_strobe(8'h10 + 8'(i));
        bus_read(A_STAT, 32'h0008_001E, "rx_full_ovr");
        for (int i = 0; i < 8; i++)
            bus_read(A_RXDATA, 32'h8000_0010 + 32'(i), $sformatf("rx_pop_%0d", i));
        bus_read(A_RXDATA, 32'h0, "rx_pop_empty");
        bus_read(A_STAT, 32'h0000_0012, "rx_empty_ovr");
        bus_write(A_STAT, 32'h10);

        // Push and pop together while full: no overflow
        for (int i = 0; i < 8; i++) rx_strobe(8'h20 + 8'(i));
        raddr = A_RXDATA; ren = 1'b1; expect_read(32'h8000_0020, "rx_pop_push_full");
        rx_data_in = 8'h28; rx_valid_in = 1'b1;
        tick();
        ren = 1'b0; rx_valid_in = 1'b0;
        bus_read(A_STAT, 32'h0008_000E, "rx_full_no_ovr");
        for (int i = 1; i < 9; i++)
            bus_read(A_RXDATA, 32'h8000_0020 + 32'(i), $sformatf("rx_drain_%0d", i));

        // RXNE interrupt
        bus_write(A_IRQEN, 32'h2);
        bus_read(A_IRQEN, 32'h2, "irqen_rb");
        check("irq_idle", {31'b0, irq_out}, 32'h0);
        rx_strobe(8'h55);
        check("irq_lag", {31'b0, irq_out}, 32'h0);
        tick();
        check("irq_rise", {31'b0, irq_out}, 32'h1);
        bus_read(A_RXDATA, 32'h8000_0055, "rx_irq_byte");
        tick();
        check("irq_fall", {31'b0, irq_out}, 32'h0);

        // Overflow interrupt, W1C, set-wins
        bus_write(A_IRQEN, 32'h4);
        for (int i = 0; i < 9; i++) rx_strobe(8'h60 + 8'(i));
        tick();
        check("irq_ovr", {31'b0, irq_out}, 32'h1);
        bus_write(A_STAT, 32'h10);
        tick();
        check("irq_ovr_clr", {31'b0, irq_out}, 32'h0);
        bus_read(A_STAT, 32'h0008_000E, "rxovr_w1c");
        waddr = A_STAT; wdata = 32'h10; wstrb = 4'hf; wen = 1'b1;
        rx_data_in = 8'h69; rx_valid_in = 1'b1;
        tick();
        wen = 1'b0; rx_valid_in = 1'b0;
        bus_read(A_STAT, 32'h0008_001E, "set_wins");
        bus_write(A_CTRL, 32'h0000_ABF5);
        bus_read(A_STAT, 32'h0000_0012, "rx_flushed");
        bus_read(A_CTRL, 32'h0000_ABF1, "flush_reads0");
        bus_write(A_STAT, 32'h10);
        bus_write(A_IRQEN, 32'h0);

        // TX flush followed by a push
        for (int i = 0; i < 4; i++) bus_write(A_TXDATA, 32'h70 + 32'(i));
        bus_read(A_STAT, 32'h0000_0400, "tx_half");
        bus_write(A_CTRL, 32'h0000_ABF3);
        check("tx_flush_valid", {23'b0, tx_valid_out, tx_data_out}, 32'h0);
        bus_write(A_TXDATA, 32'h99);
        check("tx_after_flush", {23'b0, tx_valid_out, tx_data_out}, 32'h199);
        bus_read(A_STAT, 32'h0000_0100, "txcnt_one");

        // Reset mid-activity
        rx_strobe(8'h77);
        bus_write(A_IRQEN, 32'h7);
        tick();
        tx_ready_in = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tx_ready_in = 1'b0;
        check_reset_outputs("midrst");
        bus_read(A_CTRL,  32'h0000_00F0, "midrst_ctrl");
        bus_read(A_STAT,  32'h0000_0002, "midrst_stat");
        bus_read(A_IRQEN, 32'h0,         "midrst_irqen");

        tick(); tick(); tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
